pixel_stream_framer: RTL and testbench
======================================

# pixel_stream_framer

Downstream stage of `ImageProcessTop`: consumes its filtered pixel stream (`pixel_out`/`pixel_vout`) and re-emits it as an AXI4-Stream video stream with start-of-frame (`tuser`) and end-of-line (`tlast`) markers. An internal FIFO absorbs bursts, and `slave_ready` provides early backpressure into `ImageProcessTop.master_ready`. Its output feeds the DMA/VDMA write channel.

## Interface

- `DATA_WIDTH`, 8: pixel width.
- `IMG_WIDTH`, 512: pixels per line.
- `IMG_HEIGHT`, 512: lines per frame.
- `FIFO_DEPTH`, 16: entries, power of two, ≥ 4.
- `SKID`, 4: free entries kept in reserve when `slave_ready` drops, < `FIFO_DEPTH`.

Ports:

- `axi_clk` in 1: single clock.
- `axi_rst` in 1: reset, synchronous, active-high.
- `pixel_in` in `DATA_WIDTH`: pixel from the upstream filter.
- `pixel_vin` in 1: pixel valid. There is no ready qualifier; a pixel is pushed whenever this is high.
- `slave_ready` out 1: upstream may keep sending.
- `m_axis_tdata` out `DATA_WIDTH`: output pixel.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: sink ready.
- `m_axis_tlast` out 1: last pixel of a line.
- `m_axis_tuser` out 1: first pixel of a frame.
- `frame_done` out 1: one-cycle pulse when the last pixel of a frame is transferred.
- `overflow` out 1: sticky flag; a pixel was dropped.

## Operation

- **Write side.**
  - Column counter `col` runs 0..`IMG_WIDTH`-1; row counter `row` runs 0..`IMG_HEIGHT`-1.
  - Each pixel with `pixel_vin`=1 advances `col`. When `col` wraps, `row` advances; `row` wraps to 0 after the last line.
  - Each FIFO entry stores {eof, sof, eol, data}:
    - sof = (`col`==0 && `row`==0)
    - eol = (`col`==`IMG_WIDTH`-1)
    - eof = eol && (`row`==`IMG_HEIGHT`-1)
- **Push rule.** A push is accepted if count < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - When full with no pop, the pixel is dropped and `overflow` is set until reset.
  - The counters still advance on a dropped pixel, so frame geometry stays aligned.
- **Read side.** The FIFO head drives `m_axis_*`. A pop occurs on `m_axis_tvalid && m_axis_tready`. `m_axis_tdata`, `tlast` and `tuser` stay stable while `tvalid`=1 and `tready`=0.
- **Backpressure.**
  - `slave_ready` is registered: next-cycle value = (count_next ≤ `FIFO_DEPTH` - `SKID`).
  - Upstream may issue up to `SKID`-1 further pixels after `slave_ready` falls without loss.
- **`frame_done`.** Registered one-cycle pulse in the cycle after a pop whose entry has eof=1.
- **Simultaneous push and pop.**
  - Count is unchanged.
  - When empty, a push and a pop never coincide, because `tvalid` is 0.

## Timing

- **Reset values.** All outputs are 0 while `axi_rst`=1; the FIFO is empty and `col`, `row` and `overflow` are cleared.
- **`slave_ready` after reset.** It rises 1 cycle after `axi_rst` deasserts.
- **Latency.** A pixel pushed at edge N into an empty FIFO shows `m_axis_tvalid`=1 after edge N, i.e. one cycle of latency.
- **Throughput.** One pixel per cycle when `m_axis_tready`=1 continuously.
- **`frame_done` timing.** Asserted the cycle after the eof handshake.
- **Reset mid-frame.** FIFO contents are discarded. The next accepted pixel is tagged sof, and no `frame_done` is issued for the aborted frame.
- **Pointer wrap.** The pointers are log2(`FIFO_DEPTH`) bits plus one wrap bit; full and empty are decoded from the wrap bit.

## Structure

- **Package `img_stream_pkg`.** Holds the default `IMG_WIDTH`/`IMG_HEIGHT`, the entry flag bit positions (EOL=`DATA_WIDTH`, SOF=`DATA_WIDTH`+1, EOF=`DATA_WIDTH`+2) and a `clog2`-based pointer-width constant.
- **Sub-module `sync_fifo`.** Parameterised width and depth, with push, pop, `dout`, `count`, `full` and `empty`; it is reusable by other pipeline stages.
- **Top level.** Counters, tagging, `slave_ready`, `frame_done` and `overflow` live in `pixel_stream_framer` itself.

## Test plan

Unless stated otherwise, use `IMG_WIDTH`=4, `IMG_HEIGHT`=3, `FIFO_DEPTH`=8, `SKID`=4.

- **Streaming, no backpressure.** Send 12 pixels 0x00..0x0B with `tready`=1.
  - Outputs appear one cycle later in order.
  - `tuser` is set only on 0x00; `tlast` is set on 0x03, 0x07 and 0x0B.
  - `frame_done` pulses once, the cycle after 0x0B.
- **Backpressure into upstream.** Hold `tready`=0 and stream 8 pixels.
  - `slave_ready` falls after the 5th push.
  - Entries 0..7 are all stored and `overflow`=0.
  - Releasing `tready` drains the FIFO in order.
- **Overflow.** Hold `tready`=0 and push 9 pixels.
  - The 9th is dropped and `overflow`=1.
  - The next frame's sof still lands on the 13th pixel sent.
- **Full FIFO with simultaneous push and pop.** Fill the FIFO, then push with `tready`=1 in the same cycle. The push is accepted and `overflow` stays 0.
- **Reset mid-frame.** Assert `axi_rst` for 1 cycle after 6 pixels.
  - Outputs are 0.
  - The next pixel is tagged `tuser`=1, and no `frame_done` is issued for the aborted frame.
- **Full-size frame.** With default parameters, run a 512x512 frame with random `tready`. Expect 262144 transfers, 512 `tlast`, 1 `tuser` and 1 `frame_done`.

Source files
------------

// File: rtl/img_stream_pkg.sv
// Shared constants for the pixel streaming stages: default frame geometry,
// FIFO entry flag positions and pointer sizing.
package img_stream_pkg;

  localparam int DEF_IMG_WIDTH  = 512;
  localparam int DEF_IMG_HEIGHT = 512;

  // Flags sit directly above the pixel data in a FIFO entry: {eof, sof, eol, data}
  function automatic int eol_bit(input int data_width);
    return data_width;
  endfunction

  function automatic int sof_bit(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int eof_bit(input int data_width);
    return data_width + 2;
  endfunction

  // Address bits plus one wrap bit, so full and empty are distinguishable
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head; usable by any stage.
module sync_fifo
  import img_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PW   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [PW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/pixel_stream_framer.sv
// Re-frames the filtered pixel stream as AXI4-Stream video (tuser = start of
// frame, tlast = end of line) through a FIFO with early upstream backpressure.
module pixel_stream_framer
  import img_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int FIFO_DEPTH = 16,
  parameter int SKID       = 4
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_vin,
  output logic                  slave_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int EW    = DATA_WIDTH + 3;
  localparam int PW    = ptr_width(FIFO_DEPTH);
  localparam int CW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int EOL_B = eol_bit(DATA_WIDTH);
  localparam int SOF_B = sof_bit(DATA_WIDTH);
  localparam int EOF_B = eof_bit(DATA_WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [PW-1:0] READY_MAX = PW'(FIFO_DEPTH - SKID);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          eol, sof, eof;
  logic          pop, push_ok;
  logic [EW-1:0] head;
  logic [PW-1:0] count, count_next;
  logic          fifo_full, fifo_empty;

  assign eol = (col == COL_LAST);
  assign sof = (col == '0) && (row == '0);
  assign eof = eol && (row == ROW_LAST);

  assign pop     = m_axis_tvalid && m_axis_tready;
  assign push_ok = pixel_vin && (!fifo_full || pop);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (axi_clk),
    .rst   (axi_rst),
    .push  (push_ok),
    .pop   (pop),
    .din   ({eof, sof, eol, pixel_in}),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields are masked while idle so uninitialised storage never reaches the bus
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid && head[EOL_B];
  assign m_axis_tuser  = m_axis_tvalid && head[SOF_B];

  assign count_next = count + PW'(push_ok) - PW'(pop);

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      col         <= '0;
      row         <= '0;
      slave_ready <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // Geometry advances on every valid pixel, dropped or not, to stay frame-aligned
      if (pixel_vin) begin
        if (eol) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (pixel_vin && !push_ok) overflow <= 1'b1;
      slave_ready <= (count_next <= READY_MAX);
      frame_done  <= pop && head[EOF_B];
    end
  end

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Bench for pixel_stream_framer: directed and random stimulus against a
// queue-based frame model, plus a wide-line frame on a second instance.
module tb_pixel_stream_framer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int D  = 8;
  localparam int S  = 4;
  localparam int BW = 512;
  localparam int BH = 48;
  localparam int BD = 16;
  localparam int BS = 4;
  localparam int BN = BW * BH;

  logic axi_clk = 1'b0;
  logic axi_rst = 1'b1;
  always #5 axi_clk = ~axi_clk;

  // Small instance
  logic [7:0] pixel_in = '0;
  logic       pixel_vin = 1'b0;
  logic       slave_ready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic       m_axis_tlast, m_axis_tuser, frame_done, overflow;

  // Wide-line instance
  logic [7:0] b_pixel_in = '0;
  logic       b_pixel_vin = 1'b0;
  logic       b_slave_ready;
  logic [7:0] b_tdata;
  logic       b_tvalid;
  logic       b_tready = 1'b0;
  logic       b_tlast, b_tuser, b_frame_done, b_overflow;

  pixel_stream_framer #(
    .DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D), .SKID(S)
  ) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst), .pixel_in(pixel_in), .pixel_vin(pixel_vin),
    .slave_ready(slave_ready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .frame_done(frame_done), .overflow(overflow)
  );

  pixel_stream_framer #(
    .DATA_WIDTH(8), .IMG_WIDTH(BW), .IMG_HEIGHT(BH), .FIFO_DEPTH(BD), .SKID(BS)
  ) dut_big (
    .axi_clk(axi_clk), .axi_rst(axi_rst), .pixel_in(b_pixel_in), .pixel_vin(b_pixel_vin),
    .slave_ready(b_slave_ready), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(b_tready), .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
    .frame_done(b_frame_done), .overflow(b_overflow)
  );

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } ent_t;

  ent_t q[$];
  int   pix_idx = 0;
  logic m_ready = 1'b0;
  logic m_fd = 1'b0;
  logic m_ovf = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tags follow purely from the pixel's position in the frame
  function automatic ent_t make_ent(input int idx, input logic [7:0] d);
    ent_t e;
    int   p;
    p     = idx % (W * H);
    e.data = d;
    e.sof  = (p == 0);
    e.eol  = ((p % W) == W - 1);
    e.eof  = (p == W * H - 1);
    return e;
  endfunction

  // One clock of the small instance: check outputs, then advance the model across the edge
  task automatic step(input logic vin, input logic [7:0] d, input logic rdy);
    logic pop;
    pixel_vin     = vin;
    pixel_in      = d;
    m_axis_tready = rdy;
    @(negedge axi_clk);
    check("tvalid", m_axis_tvalid, q.size() > 0);
    if (q.size() > 0) begin
      check("tdata", m_axis_tdata, q[0].data);
      check("tuser", m_axis_tuser, q[0].sof);
      check("tlast", m_axis_tlast, q[0].eol);
    end
    check("slave_ready", slave_ready, m_ready);
    check("frame_done", frame_done, m_fd);
    check("overflow", overflow, m_ovf);
    pop  = (q.size() > 0) && rdy;
    m_fd = pop && q[0].eof;
    if (pop) void'(q.pop_front());
    if (vin) begin
      if (q.size() < D) q.push_back(make_ent(pix_idx, d));
      else m_ovf = 1'b1;
      pix_idx++;
    end
    m_ready = (q.size() <= D - S);
    @(posedge axi_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    axi_rst       = 1'b1;
    pixel_vin     = 1'b0;
    m_axis_tready = 1'b0;
    b_pixel_vin   = 1'b0;
    b_tready      = 1'b0;
    repeat (n) begin
      @(posedge axi_clk);
      #1;
      check("rst_tvalid", m_axis_tvalid, 1'b0);
      check("rst_tdata", m_axis_tdata, 8'h00);
      check("rst_tlast", m_axis_tlast, 1'b0);
      check("rst_tuser", m_axis_tuser, 1'b0);
      check("rst_slave_ready", slave_ready, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_overflow", overflow, 1'b0);
    end
    q.delete();
    pix_idx = 0;
    m_ready = 1'b0;
    m_fd    = 1'b0;
    m_ovf   = 1'b0;
    axi_rst = 1'b0;
  endtask

  initial begin
    int         sent, xfers, tlasts, tusers, fds, tail;
    logic [7:0] bq[$];
    logic [7:0] d;

    // Reset, then slave_ready rises one cycle later
    do_reset(2);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Streaming with no backpressure: one full frame 0x00..0x0B
    for (int i = 0; i < 12; i++) step(1'b1, 8'(i), 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    // Backpressure: 8 pixels into a stalled sink, then drain
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    check("bp_overflow_clear", overflow, 1'b0);
    repeat (10) step(1'b0, 8'h00, 1'b1);

    // Overflow: 9th pixel dropped; 13th pixel sent still opens the next frame
    do_reset(1);
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 9; i < 14; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
    repeat (12) step(1'b0, 8'h00, 1'b1);
    check("ovf_sticky", overflow, 1'b1);

    // Full FIFO with simultaneous push and pop
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    step(1'b1, 8'h68, 1'b1);
    repeat (10) step(1'b0, 8'h00, 1'b1);
    check("full_pushpop_no_ovf", overflow, 1'b0);

    // Reset mid-frame after 6 pixels; restart must begin a fresh frame
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h80 + i), 1'b1);
    do_reset(1);
    for (int i = 0; i < 14; i++) step(1'b1, 8'(8'h90 + i), 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    // Random traffic on the small instance
    for (int i = 0; i < 400; i++) begin
      d = 8'($urandom);
      step(1'($urandom_range(0, 1)), d, $urandom_range(0, 3) != 0);
    end
    repeat (12) step(1'b0, 8'h00, 1'b1);

    // Wide-line frame on the second instance with random sink stalls
    do_reset(1);
    sent = 0; xfers = 0; tlasts = 0; tusers = 0; fds = 0; tail = 0;
    for (int cyc = 0; cyc < 60000 && tail < 4; cyc++) begin
      b_pixel_vin = (sent < BN) && b_slave_ready && ($urandom_range(0, 7) != 0);
      b_pixel_in  = 8'($urandom);
      b_tready    = ($urandom_range(0, 3) != 0);
      if (b_pixel_vin) begin
        bq.push_back(b_pixel_in);
        sent++;
      end
      @(negedge axi_clk);
      if (b_frame_done) fds++;
      if (b_tvalid && b_tready) begin
        if (bq.size() > 0) check("big_tdata", b_tdata, bq.pop_front());
        else check("big_unexpected_xfer", 1'b1, 1'b0);
        check("big_tlast", b_tlast, (xfers % BW) == BW - 1);
        check("big_tuser", b_tuser, xfers == 0);
        if (b_tlast) tlasts++;
        if (b_tuser) tusers++;
        xfers++;
      end
      if (xfers >= BN) tail++;
      @(posedge axi_clk);
      #1;
    end
    b_pixel_vin = 1'b0;
    b_tready    = 1'b0;
    check("big_transfers", xfers, BN);
    check("big_tlast_count", tlasts, BH);
    check("big_tuser_count", tusers, 1);
    check("big_frame_done_count", fds, 1);
    check("big_overflow", b_overflow, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
